ram_loader: RTL and testbench
=============================

# ram_loader

Debug-port writer that fills system RAM from a byte stream before the CPU runs. It receives bytes from an upstream receiver, such as a UART RX, over a valid/ready handshake. It assembles them into little-endian 32-bit words and writes each word through the system_if test-bench port (tbCTRL, WEN, addr, store). It holds the CPU off until the image is complete, then releases the port so the halt/readback path can inspect memory afterwards.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- MAX_WORDS, 1024: largest accepted image length in words.
- WRITE_CYCLES, 2: cycles WEN is held for each word (covers RAM write latency); minimum 1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; synchronous, active-high.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle.
- tbCTRL  out  1  loader owns the RAM port.
- WEN  out  1  RAM write enable.
- addr  out  32  RAM byte address.
- store  out  32  RAM write data.
- cpu_hold  out  1  keeps the CPU in reset while high.
- busy  out  1  a load is in progress (at least one byte accepted, not yet finished).
- done  out  1  image is written and the CPU is released.
- err  out  1  load aborted.

## Operation
- Stream format: 4-byte word count N (LSB first), then N words (each LSB first). When LOADER_CHECKSUM_EN is defined, a trailing 4-byte checksum follows the words.
- A byte transfers only when rx_valid && rx_ready.
- States:
  - LEN: collect 4 count bytes.
    - N == 0 -> DONE.
    - N > MAX_WORDS -> ERR.
    - Otherwise -> DATA.
  - DATA: collect 4 bytes into the shift register, then -> WRITE.
  - WRITE: hold WEN=1 for WRITE_CYCLES cycles with addr = BASE_ADDR + 4*idx and store = the assembled word. Then increment idx.
    - idx == N -> CSUM (macro defined) or DONE.
    - Otherwise -> DATA.
  - CSUM: collect 4 bytes and compare against the running sum.
    - Equal -> DONE.
    - Not equal -> ERR.
  - DONE, ERR: terminal. Only RST leaves them.
- rx_ready = 1 in LEN, DATA and CSUM; 0 in WRITE, DONE and ERR.
- tbCTRL = 1 in every state except DONE. In DONE, WEN, addr and store are 0, so the readback logic can take the port.
- cpu_hold = 1 in every state except DONE.
- done = (state == DONE). err = (state == ERR). In ERR the CPU stays held.
- Byte counter is 2 bits and wraps. Word index is $clog2(MAX_WORDS+1) bits. Address arithmetic is modulo 2^32.

## Timing
- Reset values (state LEN): rx_ready=1, tbCTRL=1, WEN=0, addr=0, store=0, cpu_hold=1, busy=0, done=0, err=0. Counters, index and checksum are cleared.
- Fourth byte of a word accepted at cycle t -> WEN=1 from t+1 through t+WRITE_CYCLES. DATA resumes (rx_ready=1) at t+WRITE_CYCLES+1.
- addr and store are registered. They are stable for the entire WEN window.
- rx_valid asserted while rx_ready=0: the byte is not consumed, and the upstream block must hold it.
- Last word write ends at cycle t (macro off) -> done=1 and cpu_hold=0 at t+1.
- RST asserted at any cycle: reset values at the next edge. A partial word is discarded and nothing further is written.

## Configuration
- LOADER_CHECKSUM_EN:
  - Defined: a 32-bit wrapping sum of all data words is accumulated, and the CSUM state exists. A mismatch -> ERR.
  - Undefined: no accumulator and no CSUM state; the last write goes straight to DONE.

## Structure
- cpu_types_pkg receives:
  - loader_state_t enum (LEN, DATA, WRITE, CSUM, DONE, ERR).
  - LOADER_BYTES_PER_WORD = 4.
- Sub-module byte_packer: shifts in 4 bytes LSB-first and presents word plus word_valid. The top-level FSM, address counter, WEN timer and checksum sit in ram_loader.

## Test plan
- Stream 02 00 00 00, 78 56 34 12, EF BE AD DE (macro off) -> two WEN windows of WRITE_CYCLES cycles:
  - addr=0x0, store=0x12345678.
  - addr=0x4, store=0xDEADBEEF.
  - Then done=1, cpu_hold=0, tbCTRL=0.
- Count 00 00 00 00 -> done=1 one cycle after the fourth byte, no WEN pulse.
- Count MAX_WORDS+1 -> err=1, rx_ready=0, cpu_hold=1, no writes.
- rx_valid held high during WRITE -> the byte is not consumed until rx_ready returns. Store data matches the stream with no dropped or duplicated bytes.
- Checksum (macro on), words 1 and 2:
  - Trailer 03 00 00 00 -> done=1.
  - Trailer 04 00 00 00 -> err=1.
- RST pulsed after 6 bytes (mid word 1), then a fresh 1-word stream with word 0xCAFEF00D -> single write at addr=BASE_ADDR with store=0xCAFEF00D, then done=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared loader types, FSM state encodings and word geometry
package cpu_types_pkg;
   localparam int LOADER_BYTES_PER_WORD = 4;
   typedef enum logic [2:0] {LEN, DATA, WRITE, CSUM, DONE, ERR} loader_state_t;
   localparam logic [2:0] ST_LEN   = 3'(LEN);
   localparam logic [2:0] ST_DATA  = 3'(DATA);
   localparam logic [2:0] ST_WRITE = 3'(WRITE);
   localparam logic [2:0] ST_CSUM  = 3'(CSUM);
   localparam logic [2:0] ST_DONE  = 3'(DONE);
   localparam logic [2:0] ST_ERR   = 3'(ERR);
endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: byte-stream handshake plus the system test-bench RAM port
interface ram_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        tbCTRL;
   logic        WEN;
   logic [31:0] addr;
   logic [31:0] store;
   modport master (input rx_data, rx_valid, output rx_ready, tbCTRL, WEN, addr, store);
   modport slave  (output rx_data, rx_valid, input rx_ready, tbCTRL, WEN, addr, store);
endinterface

// File: rtl/ram_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from accepted bytes
module byte_packer
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  data,
   input  logic        take,
   output logic [31:0] word,
   output logic        word_valid
);
   logic [23:0] sr;
   logic [1:0]  cnt;
   // word is presented combinationally in the cycle its last byte is taken
   assign word = {data, sr};
   assign word_valid = take && cnt == 2'(LOADER_BYTES_PER_WORD - 1);
   // earlier bytes shift down so the first byte lands in the low lane
   always_ff @(posedge CLK) begin
      if (RST) begin
         sr  <= '0;
         cnt <= '0;
      end else if (take) begin
         sr  <= {data, sr[23:8]};
         cnt <= cnt + 2'd1;
      end
   end
endmodule

// File: rtl/ram_loader.sv
// ram_loader: fills RAM from a byte stream, holds the CPU until done
// Optional trailing checksum check is enabled by defining LOADER_CHECKSUM_EN.
module ram_loader
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          MAX_WORDS    = 1024,
   parameter int          WRITE_CYCLES = 2
) (
   input  logic          CLK,
   input  logic          RST,
   ram_loader_if.master  bus,
   output logic          cpu_hold,
   output logic          busy,
   output logic          done,
   output logic          err
);
   localparam int IW = $clog2(MAX_WORDS + 1);
`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] ST_TAIL = ST_CSUM;
   logic [31:0]   csum;
`else
   localparam logic [2:0] ST_TAIL = ST_DONE;
`endif
   logic [2:0]    state;
   logic [IW-1:0] idx, n;
   logic [15:0]   wcnt;
   logic [31:0]   addr_q, store_q, word;
   logic          seen, take, wv;
   assign take         = bus.rx_valid && bus.rx_ready;
   assign bus.rx_ready = state == ST_LEN || state == ST_DATA || state == ST_CSUM;
   assign bus.tbCTRL   = state != ST_DONE;
   assign bus.WEN      = state == ST_WRITE;
   assign bus.addr     = addr_q;
   assign bus.store    = store_q;
   assign cpu_hold     = state != ST_DONE;
   assign done         = state == ST_DONE;
   assign err          = state == ST_ERR;
   assign busy         = seen && !done && !err;
   byte_packer u_packer (
      .CLK(CLK), .RST(RST), .data(bus.rx_data), .take(take), .word(word), .word_valid(wv)
   );
   // load sequencer: count, word capture, timed write window, optional checksum
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_LEN;
         idx     <= '0;
         n       <= '0;
         wcnt    <= '0;
         addr_q  <= '0;
         store_q <= '0;
         seen    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum    <= '0;
`endif
      end else begin
         seen <= seen | take;
         case (state)
            ST_LEN: if (wv) begin
               n     <= word[IW-1:0];
               state <= word == 32'd0 ? ST_DONE : word > 32'(MAX_WORDS) ? ST_ERR : ST_DATA;
            end
            ST_DATA: if (wv) begin
               addr_q  <= BASE_ADDR + (32'(idx) << 2);
               store_q <= word;
               wcnt    <= '0;
               state   <= ST_WRITE;
`ifdef LOADER_CHECKSUM_EN
               csum    <= csum + word;
`endif
            end
            ST_WRITE: if (wcnt == 16'(WRITE_CYCLES - 1)) begin
               addr_q  <= '0;
               store_q <= '0;
               idx     <= idx + 1'b1;
               state   <= idx + 1'b1 == n ? ST_TAIL : ST_DATA;
            end else begin
               wcnt <= wcnt + 16'd1;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: if (wv) state <= word == csum ? ST_DONE : ST_ERR;
`endif
            default: state <= state;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed stream tests with a write scoreboard for ram_loader
module tb_ram_loader;
   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam int MAXW = 1024;
   localparam int WC   = 2;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic cpu_hold, busy, done, err;
   int checks = 0, errors = 0, writes = 0, wlen = 0, w0 = 0;
   logic wen_prev = 1'b0;
   logic [63:0] sb[$];
   logic [63:0] e;
   logic [31:0] cur_a = '0, cur_s = '0;
   ram_loader_if bus();
   ram_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .WRITE_CYCLES(WC)) dut (
      .CLK(CLK), .RST(RST), .bus(bus), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   // scoreboard: each WEN window is matched against the next expected write
   always @(negedge CLK) begin
      if (bus.WEN === 1'b1) begin
         if (!wen_prev) begin
            writes++;
            wlen = 1;
            chk("write_expected", 32'(sb.size() == 0), 32'd0);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               cur_a = e[63:32];
               cur_s = e[31:0];
               chk("wr_addr", bus.addr, cur_a);
               chk("wr_store", bus.store, cur_s);
            end
         end else begin
            wlen++;
            chk("addr_stable", bus.addr, cur_a);
            chk("store_stable", bus.store, cur_s);
         end
      end else if (wen_prev) begin
         chk("wen_len", 32'(wlen), 32'(WC));
      end
      wen_prev = bus.WEN;
   end
   task automatic send(input logic [7:0] b);
      int k;
      bus.rx_data = b;
      bus.rx_valid = 1'b1;
      k = 0;
      while (bus.rx_ready !== 1'b1 && k < 50) begin
         @(negedge CLK);
         k++;
      end
      chk("ready_timeout", 32'(k < 50), 32'd1);
      @(negedge CLK);
   endtask
   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
   endtask
   task automatic wait_end();
      int k;
      k = 0;
      while (!(done || err) && k < 40) begin
         @(negedge CLK);
         k++;
      end
   endtask
   task automatic do_reset();
      bus.rx_valid = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
   endtask
   task automatic check_reset();
      chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
      chk("rst_tbctrl", 32'(bus.tbCTRL), 32'd1);
      chk("rst_wen", 32'(bus.WEN), 32'd0);
      chk("rst_addr", bus.addr, 32'd0);
      chk("rst_store", bus.store, 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
   endtask
   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data = 8'h00;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      check_reset();
      sb.push_back({BASE, 32'h1234_5678});
      sb.push_back({BASE + 32'd4, 32'hDEAD_BEEF});
      w0 = writes;
      send_word(32'd2);
      chk("busy_in_load", 32'(busy), 32'd1);
      send_word(32'h1234_5678);
      chk("wen_latency", 32'(bus.WEN), 32'd1);
      chk("ready_low_write", 32'(bus.rx_ready), 32'd0);
      send_word(32'hDEAD_BEEF);
`ifdef LOADER_CHECKSUM_EN
      send_word(32'hF0E2_1567);
`endif
      bus.rx_valid = 1'b0;
      wait_end();
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_err", 32'(err), 32'd0);
      chk("t1_hold", 32'(cpu_hold), 32'd0);
      chk("t1_tbctrl", 32'(bus.tbCTRL), 32'd0);
      chk("t1_addr", bus.addr, 32'd0);
      chk("t1_store", bus.store, 32'd0);
      chk("t1_writes", 32'(writes - w0), 32'd2);
      chk("t1_sb_empty", 32'(sb.size()), 32'd0);
      do_reset();
      w0 = writes;
      send_word(32'd0);
      chk("t2_done", 32'(done), 32'd1);
      bus.rx_valid = 1'b0;
      repeat (3) @(negedge CLK);
      chk("t2_writes", 32'(writes - w0), 32'd0);
      chk("t2_ready", 32'(bus.rx_ready), 32'd0);
      do_reset();
      send_word(32'(MAXW));
      chk("max_ok_err", 32'(err), 32'd0);
      chk("max_ok_ready", 32'(bus.rx_ready), 32'd1);
      do_reset();
      w0 = writes;
      send_word(32'(MAXW + 1));
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_ready", 32'(bus.rx_ready), 32'd0);
      chk("t3_hold", 32'(cpu_hold), 32'd1);
      chk("t3_done", 32'(done), 32'd0);
      chk("t3_busy", 32'(busy), 32'd0);
      bus.rx_valid = 1'b0;
      repeat (3) @(negedge CLK);
      chk("t3_writes", 32'(writes - w0), 32'd0);
`ifdef LOADER_CHECKSUM_EN
      do_reset();
      sb.push_back({BASE, 32'd1});
      sb.push_back({BASE + 32'd4, 32'd2});
      send_word(32'd2);
      send_word(32'd1);
      send_word(32'd2);
      send_word(32'd3);
      bus.rx_valid = 1'b0;
      wait_end();
      chk("cs_good_done", 32'(done), 32'd1);
      do_reset();
      sb.push_back({BASE, 32'd1});
      sb.push_back({BASE + 32'd4, 32'd2});
      send_word(32'd2);
      send_word(32'd1);
      send_word(32'd2);
      send_word(32'd4);
      bus.rx_valid = 1'b0;
      wait_end();
      chk("cs_bad_err", 32'(err), 32'd1);
      chk("cs_bad_hold", 32'(cpu_hold), 32'd1);
`endif
      do_reset();
      send_word(32'd1);
      send(8'h0D);
      send(8'hF0);
      do_reset();
      check_reset();
      sb.push_back({BASE, 32'hCAFE_F00D});
      w0 = writes;
      send_word(32'd1);
      send_word(32'hCAFE_F00D);
`ifdef LOADER_CHECKSUM_EN
      send_word(32'hCAFE_F00D);
`endif
      bus.rx_valid = 1'b0;
      wait_end();
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_writes", 32'(writes - w0), 32'd1);
      chk("t5_sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
